down_count_timer: RTL

- Loadable countdown timer: free-running prescaler divides `clk` into a periodic tick; each tick decrements a WIDTH-bit count toward zero.
- Signals terminal count (`tc`) and completion (`done`).
- Counterpart to the team's up-counter; drives countdown displays and timeouts from the same 27 MHz board clock.

---
 rtl/down_count_timer.sv | 119 +++++++++++
 1 files changed

// File: rtl/down_count_timer.sv
// Loadable countdown timer: a prescaler turns clk into a tick every DIV cycles and each tick decrements Cout.
// Build option DOWN_COUNT_AUTO_RELOAD_EN: on reaching zero, reload the last loaded value and keep running.
module down_count_timer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 27000000
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] Cout,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] cout_reg;
  logic [PRE_W-1:0] pre_reg;
  logic             tc_reg;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_reg;
`endif

  // One cycle of counting, shared by RUN and the resume edge out of PAUSE.
  logic             tick;
  logic [PRE_W-1:0] pre_step;
  logic [WIDTH-1:0] cout_step;
  logic             tc_step;
  logic             to_done;

  always_comb begin
    tick      = (pre_reg == PRE_LAST);
    pre_step  = tick ? '0 : pre_reg + PRE_W'(1);
    cout_step = cout_reg;
    tc_step   = 1'b0;
    to_done   = 1'b0;
    if (tick) begin
      if (cout_reg > WIDTH'(1)) begin
        cout_step = cout_reg - WIDTH'(1);
      end else begin
        tc_step = 1'b1;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
        cout_step = reload_reg;
`else
        cout_step = '0;
        to_done   = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg  <= IDLE;
      cout_reg   <= '0;
      pre_reg    <= '0;
      tc_reg     <= 1'b0;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else begin
      tc_reg <= 1'b0;
      if (load) begin
        // Load outranks everything; only a nonzero load keeps a running timer running.
        cout_reg <= load_val;
        pre_reg  <= '0;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
        reload_reg <= load_val;
`endif
        if (state_reg != RUN || load_val == '0) begin
          state_reg <= IDLE;
        end
      end else begin
        unique case (state_reg)
          IDLE: begin
            if (start && cout_reg != '0) begin
              state_reg <= RUN;
              pre_reg   <= '0;
            end
          end
          RUN: begin
            if (stop) begin
              state_reg <= PAUSE;
            end else begin
              pre_reg  <= pre_step;
              cout_reg <= cout_step;
              tc_reg   <= tc_step;
              if (to_done) state_reg <= DONE;
            end
          end
          PAUSE: begin
            if (start) begin
              state_reg <= to_done ? DONE : RUN;
              pre_reg   <= pre_step;
              cout_reg  <= cout_step;
              tc_reg    <= tc_step;
            end
          end
          DONE: begin
          end
        endcase
      end
    end
  end

  assign Cout = cout_reg;
  assign tc   = tc_reg;
  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

endmodule
